// File: rtl/cnf_load_frontend.sv
// cnf_load_frontend
//   Ingress stage between a host DIMACS literal stream and the solver load port.
//   Literals pass through a small FIFO. Each accepted literal is checked against the
//   solver capacity limits. The block keeps running clause/literal/max-variable counts.
//   start_solve is held back until the FIFO has drained. Any violation latches a sticky
//   error, and from then on the solver is never started.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_literal/
//   in_clause_end/in_ready      host literal stream (valid/ready)
//   host_start, host_clear      solve request pulse, synchronous flush back to LOAD
//   load_valid/load_literal/
//   load_clause_end/load_ready  registered FIFO head towards the solver (valid/ready)
//   start_solve, solver_done    one-cycle solve pulse, solver completion
//   busy, error, err_code       status (err_code: 1 zero, 2 range, 3 clause len,
//                               4 clause count, 5 literal count, 6 partial clause)
//   clause_count, lit_count,
//   max_var                     statistics of the accepted literals

module cnf_load_frontend #(
    parameter int unsigned MAX_VARS       = 256,
    parameter int unsigned MAX_CLAUSES    = 1024,
    parameter int unsigned MAX_LITS       = 8192,
    parameter int unsigned MAX_CLAUSE_LEN = 32,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic [31:0]                      in_literal,
    input  logic                             in_clause_end,
    output logic                             in_ready,
    input  logic                             host_start,
    input  logic                             host_clear,
    output logic                             load_valid,
    output logic [31:0]                      load_literal,
    output logic                             load_clause_end,
    input  logic                             load_ready,
    output logic                             start_solve,
    input  logic                             solver_done,
    output logic                             busy,
    output logic                             error,
    output logic [2:0]                       err_code,
    output logic [$clog2(MAX_CLAUSES+1)-1:0] clause_count,
    output logic [$clog2(MAX_LITS+1)-1:0]    lit_count,
    output logic [$clog2(MAX_VARS+1)-1:0]    max_var
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CC_W  = $clog2(MAX_CLAUSES + 1);
    localparam int unsigned LC_W  = $clog2(MAX_LITS + 1);
    localparam int unsigned MV_W  = $clog2(MAX_VARS + 1);
    localparam int unsigned LEN_W = $clog2(MAX_CLAUSE_LEN + 1);

    localparam logic [32:0]      MaxVarsC    = 33'(MAX_VARS);
    localparam logic [LEN_W-1:0] MaxLenC     = LEN_W'(MAX_CLAUSE_LEN);
    localparam logic [CC_W-1:0]  MaxClausesC = CC_W'(MAX_CLAUSES);
    localparam logic [LC_W-1:0]  MaxLitsC    = LC_W'(MAX_LITS);
    localparam logic [CNT_W-1:0] DepthC      = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] ErrNone      = 3'd0;
    localparam logic [2:0] ErrZeroLit   = 3'd1;
    localparam logic [2:0] ErrVarRange  = 3'd2;
    localparam logic [2:0] ErrClauseLen = 3'd3;
    localparam logic [2:0] ErrClauseCnt = 3'd4;
    localparam logic [2:0] ErrLitCnt    = 3'd5;
    localparam logic [2:0] ErrPartial   = 3'd6;

    typedef enum logic [2:0] {
        StLoad,
        StDrain,
        StStart,
        StSolving,
        StDone,
        StError
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         err_code_q, err_code_d;
    logic [LEN_W-1:0]   cur_len_q, cur_len_d;
    logic [CC_W-1:0]    clause_cnt_q, clause_cnt_d;
    logic [LC_W-1:0]    lit_cnt_q, lit_cnt_d;
    logic [MV_W-1:0]    max_var_q, max_var_d;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               head_vld_q, head_vld_d;
    logic [31:0]        head_lit_q, head_lit_d;
    logic               head_ce_q, head_ce_d;
    logic [32:0]        mem_q [FIFO_DEPTH];

    logic               accept;
    logic               push;
    logic               pop;
    logic [32:0]        lit_ext;
    logic [32:0]        lit_abs;
    logic [MV_W-1:0]    lit_mag;
    logic [2:0]         lit_code;
    logic [PTR_W-1:0]   head_idx;

    // Output decode, all from registered state.
    always_comb begin
        in_ready        = (state_q == StLoad) && (count_q != DepthC);
        load_valid      = head_vld_q && ((state_q == StLoad) || (state_q == StDrain));
        load_literal    = head_lit_q;
        load_clause_end = head_ce_q;
        start_solve     = (state_q == StStart);
        busy            = (state_q != StLoad);
        error           = (state_q == StError);
        err_code        = err_code_q;
        clause_count    = clause_cnt_q;
        lit_count       = lit_cnt_q;
        max_var         = max_var_q;
    end

    // Literal checks in priority order. The magnitude is taken in 33 bits so that
    // -2^31 yields +2^31 and falls out of range instead of wrapping.
    always_comb begin
        lit_ext = {in_literal[31], in_literal};
        lit_abs = in_literal[31] ? (33'd0 - lit_ext) : lit_ext;
        lit_mag = lit_abs[MV_W-1:0];
        if (in_literal == 32'd0) begin
            lit_code = ErrZeroLit;
        end else if (lit_abs > MaxVarsC) begin
            lit_code = ErrVarRange;
        end else if (cur_len_q == MaxLenC) begin
            lit_code = ErrClauseLen;
        end else if (in_clause_end && (clause_cnt_q == MaxClausesC)) begin
            lit_code = ErrClauseCnt;
        end else if (lit_cnt_q == MaxLitsC) begin
            lit_code = ErrLitCnt;
        end else begin
            lit_code = ErrNone;
        end
    end

    always_comb begin
        accept = in_valid && in_ready;
        push   = accept && (lit_code == ErrNone);
        pop    = load_valid && load_ready;
    end

    // FIFO bookkeeping. The head register only picks up entries that were already
    // stored before this edge, which gives the one-cycle first-word latency and means
    // a slot being written this cycle is never read back early.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        head_idx   = pop ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        head_vld_d = pop ? (count_q > CNT_W'(1)) : (count_q != '0);
        head_lit_d = mem_q[head_idx][31:0];
        head_ce_d  = mem_q[head_idx][32];
        if (host_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            head_vld_d = 1'b0;
            head_lit_d = '0;
            head_ce_d  = 1'b0;
        end
    end

    // Control FSM and statistics counters.
    always_comb begin
        state_d      = state_q;
        err_code_d   = err_code_q;
        cur_len_d    = cur_len_q;
        clause_cnt_d = clause_cnt_q;
        lit_cnt_d    = lit_cnt_q;
        max_var_d    = max_var_q;

        unique case (state_q)
            StLoad: begin
                if (accept && (lit_code != ErrNone)) begin
                    state_d    = StError;
                    err_code_d = lit_code;
                end else if (host_start) begin
                    if (cur_len_q == '0) begin
                        state_d = StDrain;
                    end else begin
                        state_d    = StError;
                        err_code_d = ErrPartial;
                    end
                end
            end
            StDrain: begin
                if (count_q == '0) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                state_d = StSolving;
            end
            StSolving: begin
                if (solver_done) begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (push) begin
            lit_cnt_d = lit_cnt_q + LC_W'(1);
            if (lit_mag > max_var_q) begin
                max_var_d = lit_mag;
            end
            if (in_clause_end) begin
                cur_len_d    = '0;
                clause_cnt_d = clause_cnt_q + CC_W'(1);
            end else begin
                cur_len_d = cur_len_q + LEN_W'(1);
            end
        end

        if (host_clear) begin
            state_d      = StLoad;
            err_code_d   = ErrNone;
            cur_len_d    = '0;
            clause_cnt_d = '0;
            lit_cnt_d    = '0;
            max_var_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StLoad;
            err_code_q   <= ErrNone;
            cur_len_q    <= '0;
            clause_cnt_q <= '0;
            lit_cnt_q    <= '0;
            max_var_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_vld_q   <= 1'b0;
            head_lit_q   <= '0;
            head_ce_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_code_q   <= err_code_d;
            cur_len_q    <= cur_len_d;
            clause_cnt_q <= clause_cnt_d;
            lit_cnt_q    <= lit_cnt_d;
            max_var_q    <= max_var_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_vld_q   <= head_vld_d;
            head_lit_q   <= head_lit_d;
            head_ce_q    <= head_ce_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_clause_end, in_literal};
        end
    end

endmodule

// File: tb/tb_cnf_load_frontend.sv
module tb_cnf_load_frontend;

    localparam int MAX_VARS    = 256;
    localparam int MAX_CLAUSES = 1024;
    localparam int MAX_LITS    = 8192;
    localparam int MAX_LEN     = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_literal;
    logic        in_clause_end;
    logic        in_ready;
    logic        host_start;
    logic        host_clear;
    logic        load_valid;
    logic [31:0] load_literal;
    logic        load_clause_end;
    logic        load_ready;
    logic        start_solve;
    logic        solver_done;
    logic        busy;
    logic        error;
    logic [2:0]  err_code;
    logic [10:0] clause_count;
    logic [13:0] lit_count;
    logic [8:0]  max_var;

    cnf_load_frontend dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_literal      (in_literal),
        .in_clause_end   (in_clause_end),
        .in_ready        (in_ready),
        .host_start      (host_start),
        .host_clear      (host_clear),
        .load_valid      (load_valid),
        .load_literal    (load_literal),
        .load_clause_end (load_clause_end),
        .load_ready      (load_ready),
        .start_solve     (start_solve),
        .solver_done     (solver_done),
        .busy            (busy),
        .error           (error),
        .err_code        (err_code),
        .clause_count    (clause_count),
        .lit_count       (lit_count),
        .max_var         (max_var)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the solver-side view of what the host has loaded so far.
    typedef struct {
        logic [31:0] lit;
        logic        ce;
    } beat_t;

    beat_t exp_q[$];
    int    m_cur_len, m_clauses, m_lits, m_maxvar, m_err, m_phase;
    int    start_cnt = 0;
    int    beat_cnt  = 0;

    function automatic int model_code(input logic [31:0] lit, input logic ce);
        longint mag = longint'($signed(lit));
        if (mag < 0) mag = -mag;
        if (lit == 32'd0) return 1;
        if (mag > MAX_VARS) return 2;
        if (m_cur_len == MAX_LEN) return 3;
        if (ce && m_clauses == MAX_CLAUSES) return 4;
        if (m_lits == MAX_LITS) return 5;
        return 0;
    endfunction

    task automatic model_accept(input logic [31:0] lit, input logic ce);
        int     code = model_code(lit, ce);
        longint mag  = longint'($signed(lit));
        beat_t  b;
        if (mag < 0) mag = -mag;
        if (code != 0) begin
            if (m_err == 0) m_err = code;
        end else begin
            b.lit = lit;
            b.ce  = ce;
            exp_q.push_back(b);
            m_lits++;
            if (int'(mag) > m_maxvar) m_maxvar = int'(mag);
            if (ce) begin
                m_cur_len = 0;
                m_clauses++;
            end else begin
                m_cur_len++;
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cur_len = 0;
        m_clauses = 0;
        m_lits    = 0;
        m_maxvar  = 0;
        m_err     = 0;
        m_phase   = 0;
    endtask

    // Solver-side monitor, sampled mid-cycle.
    always @(negedge clk) begin : mon
        beat_t b;
        if (rst_n) begin
            if (load_valid && load_ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: literal 0x%0h with empty model queue",
                             load_literal);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_lit", load_literal, b.lit);
                    check("beat_ce", load_clause_end, b.ce);
                end
            end
            if (start_solve) begin
                start_cnt++;
                check("start_fifo_empty", exp_q.size(), 0);
                check("start_load_valid", load_valid, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] lit, input logic ce);
        int t = 0;
        in_valid = 1'b0;
        while (!in_ready && t < 100) begin
            step();
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready 0 required 1 for literal 0x%0h", lit);
            return;
        end
        in_literal    = lit;
        in_clause_end = ce;
        in_valid      = 1'b1;
        model_accept(lit, ce);
        step();
        in_valid = 1'b0;
    endtask

    task automatic start_pulse();
        host_start = 1'b1;
        if (m_err == 0 && m_phase == 0) begin
            if (m_cur_len != 0) m_err = 6;
            else m_phase = 1;
        end
        step();
        host_start = 1'b0;
    endtask

    task automatic clear_all();
        host_clear  = 1'b1;
        in_valid    = 1'b0;
        host_start  = 1'b0;
        load_ready  = 1'b0;
        solver_done = 1'b0;
        step();
        host_clear = 1'b0;
        model_reset();
    endtask

    task automatic check_counts();
        check("clause_count", clause_count, m_clauses);
        check("lit_count", lit_count, m_lits);
        check("max_var", max_var, m_maxvar);
        check("err_code", err_code, m_err);
    endtask

    task automatic wait_start(input int prev);
        int t = 0;
        while (start_cnt == prev && t < 200) begin
            step();
            t++;
        end
        check("start_seen", start_cnt, prev + 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            step();
            t++;
        end
        check("drained", exp_q.size(), 0);
    endtask

    typedef struct {
        logic [31:0] lit;
        logic        ce;
        logic [2:0]  code;
    } vec_t;

    vec_t vecs[11];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int sc;
        int bc;
        logic [31:0] lit;
        logic        ce;

        vecs[0]  = '{32'd1, 1'b1, 3'd0};
        vecs[1]  = '{32'hffff_ffff, 1'b1, 3'd0};
        vecs[2]  = '{32'd256, 1'b1, 3'd0};
        vecs[3]  = '{32'hffff_ff00, 1'b0, 3'd0};
        vecs[4]  = '{32'd257, 1'b1, 3'd2};
        vecs[5]  = '{32'hffff_feff, 1'b1, 3'd2};
        vecs[6]  = '{32'd0, 1'b1, 3'd1};
        vecs[7]  = '{32'd0, 1'b0, 3'd1};
        vecs[8]  = '{32'h8000_0000, 1'b1, 3'd2};
        vecs[9]  = '{32'h7fff_ffff, 1'b0, 3'd2};
        vecs[10] = '{32'd5, 1'b0, 3'd0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_literal = '0; in_clause_end = 1'b0;
        host_start = 1'b0; host_clear = 1'b0; load_ready = 1'b0; solver_done = 1'b0;
        model_reset();
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset state.
        check("rst_in_ready", in_ready, 1);
        check("rst_load_valid", load_valid, 0);
        check("rst_load_literal", load_literal, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_start", start_solve, 0);
        check_counts();

        // Three clauses, first-word latency, deferred start.
        load_ready = 1'b1;
        in_literal = 32'd1; in_clause_end = 1'b0; in_valid = 1'b1;
        model_accept(32'd1, 1'b0);
        step();
        in_valid = 1'b0;
        check("latency_edge_n", load_valid, 0);
        step();
        check("latency_edge_n1", load_valid, 1);
        push(-32'sd2, 1'b1);
        push(32'd2, 1'b0);
        push(32'd3, 1'b1);
        push(-32'sd1, 1'b1);
        start_pulse();
        wait_start(0);
        check("basic_beats", beat_cnt, 5);
        check_counts();
        check("basic_clauses", clause_count, 3);
        check("basic_maxvar", max_var, 3);
        repeat (3) step();
        check("start_once", start_cnt, 1);
        check("solving_busy", busy, 1);
        solver_done = 1'b1;
        step();
        solver_done = 1'b0;
        check("done_in_ready", in_ready, 0);
        check("done_error", error, 0);
        start_pulse();
        repeat (3) step();
        check("done_start_ignored", start_cnt, 1);

        // Literal classification table.
        foreach (vecs[i]) begin
            clear_all();
            load_ready = 1'b1;
            push(vecs[i].lit, vecs[i].ce);
            check("vec_err_code", err_code, vecs[i].code);
            check("vec_error", error, vecs[i].code != 0);
            check("vec_in_ready", in_ready, vecs[i].code == 0);
            check("vec_lit_count", lit_count, (vecs[i].code == 0) ? 1 : 0);
        end

        // Out-of-range literal then host_start: no solve; clear recovers.
        clear_all();
        load_ready = 1'b1;
        push(32'd257, 1'b1);
        sc = start_cnt;
        start_pulse();
        repeat (4) step();
        check("err_no_start", start_cnt, sc);
        check("err_code_2", err_code, 2);
        check("err_load_valid", load_valid, 0);
        clear_all();
        check("clear_busy", busy, 0);
        check("clear_error", error, 0);
        check("clear_in_ready", in_ready, 1);
        check_counts();

        // FIFO full with stalled solver, then drain.
        clear_all();
        bc = beat_cnt;
        for (int i = 1; i <= 16; i++) push(i, 1'b1);
        check("full_in_ready", in_ready, 0);
        check("full_load_valid", load_valid, 1);
        load_ready = 1'b1;
        step();
        check("in_ready_reassert", in_ready, 1);
        push(32'd17, 1'b1);
        wait_drain();
        check("full_beats", beat_cnt - bc, 17);
        check_counts();

        // Over-long clause.
        clear_all();
        load_ready = 1'b1;
        for (int i = 1; i <= MAX_LEN; i++) push(i, 1'b0);
        check("len32_ok", err_code, 0);
        push(32'd33, 1'b0);
        check("len33_code", err_code, 3);
        check("len33_lits", lit_count, MAX_LEN);

        // Partial clause at host_start.
        clear_all();
        load_ready = 1'b1;
        push(32'd1, 1'b0);
        push(32'd2, 1'b0);
        sc = start_cnt;
        start_pulse();
        repeat (5) step();
        check("partial_code", err_code, 6);
        check("partial_error", error, 1);
        check("partial_no_start", start_cnt, sc);

        // Asynchronous reset while draining.
        clear_all();
        push(32'd1, 1'b0);
        push(32'd2, 1'b1);
        push(32'd3, 1'b0);
        push(32'd4, 1'b0);
        push(32'd5, 1'b1);
        start_pulse();
        step();
        check("drain_busy", busy, 1);
        check("drain_load_valid", load_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_load_valid", load_valid, 0);
        check("arst_busy", busy, 0);
        model_reset();
        step();
        rst_n = 1'b1;
        step();
        check("arst_in_ready", in_ready, 1);
        check("arst_load_valid2", load_valid, 0);
        check_counts();

        // Clause-count limit.
        clear_all();
        load_ready = 1'b1;
        for (int i = 0; i < MAX_CLAUSES; i++) push((i % MAX_VARS) + 1, 1'b1);
        push(32'd5, 1'b1);
        check("clause_limit_code", err_code, 4);
        check_counts();

        // Literal-count limit.
        clear_all();
        load_ready = 1'b1;
        for (int c = 0; c < MAX_CLAUSES; c++) begin
            for (int j = 0; j < 8; j++) push(((c * 8 + j) % MAX_VARS) + 1, j == 7);
        end
        push(32'd7, 1'b0);
        check("lit_limit_code", err_code, 5);
        check_counts();

        // Randomized traffic against the model.
        clear_all();
        for (int n = 0; n < 600; n++) begin
            check_counts();
            load_ready = ($urandom_range(0, 1) == 1);
            lit = $urandom_range(1, MAX_VARS);
            if ($urandom_range(0, 1) == 1) lit = -lit;
            ce = (m_cur_len == MAX_LEN - 1) || ($urandom_range(0, 3) == 0);
            in_literal    = lit;
            in_clause_end = ce;
            in_valid      = ($urandom_range(0, 9) < 7);
            if (in_valid && in_ready) model_accept(lit, ce);
            step();
        end
        in_valid = 1'b0;
        if (m_cur_len != 0) push(32'd9, 1'b1);
        load_ready = 1'b1;
        sc = start_cnt;
        start_pulse();
        wait_start(sc);
        check_counts();
        check("rand_busy", busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
